game_round_ctrl: RTL

Round sequencer for the binary mental-math game. It owns a 4-bit LFSR random source and gates its advance. It samples two operands per round, presents them to the player, and times the answer window. It checks the player's 5-bit binary sum and accumulates a score over a fixed number of rounds. It sits between the player I/O (switches, buttons, display) and the random source.

---
 rtl/game_round_ctrl_pkg.sv | 29 ++
 rtl/game_round_ctrl_if.sv | 39 +++
 rtl/game_round_ctrl_rng_lfsr4.sv | 38 +++
 rtl/game_round_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/game_round_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the binary mental-math round sequencer:
//   - state_t : round sequencer states (IDLE, LOAD_A, LOAD_B, SHOW, NEXT, DONE)
//   - OP_W    : operand width (4 bits, one LFSR sample)
//   - ANS_W   : answer width (5 bits, holds any OP_W + OP_W sum)
//   - op_sum  : zero-extended operand sum used for answer checking
// -----------------------------------------------------------------------------
package game_pkg;

   localparam int OP_W  = 4;
   localparam int ANS_W = 5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      SHOW   = 3'd3,
      NEXT   = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Two 4-bit operands never overflow a 5-bit sum.
   function automatic logic [ANS_W-1:0] op_sum(input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b);
      return ANS_W'(a) + ANS_W'(b);
   endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_round_ctrl_if
// Player-facing bundle of the round sequencer.
//   master (player side / bench) drives : start, ans_valid, ans
//   slave  (game_round_ctrl) drives     : op_a, op_b, show, correct, wrong,
//                                         timeout, score, round_no, busy, done
// SCORE_W must match the SCORE_W of the attached game_round_ctrl.
// -----------------------------------------------------------------------------
interface game_round_ctrl_if #(
   parameter int SCORE_W = 4
);

   logic                        start;
   logic                        ans_valid;
   logic [game_pkg::ANS_W-1:0]  ans;
   logic [game_pkg::OP_W-1:0]   op_a;
   logic [game_pkg::OP_W-1:0]   op_b;
   logic                        show;
   logic                        correct;
   logic                        wrong;
   logic                        timeout;
   logic [SCORE_W-1:0]          score;
   logic [7:0]                  round_no;
   logic                        busy;
   logic                        done;

   modport master (
      output start, ans_valid, ans,
      input  op_a, op_b, show, correct, wrong, timeout, score, round_no,
             busy, done
   );

   modport slave (
      input  start, ans_valid, ans,
      output op_a, op_b, show, correct, wrong, timeout, score, round_no,
             busy, done
   );

endinterface

// File: rtl/game_round_ctrl_rng_lfsr4.sv
// -----------------------------------------------------------------------------
// rng_lfsr4
// 4-bit random source for operand sampling.
//   next = {q[2], q[1], q[0] ~^ q[3], q[3]}; from 0000 it runs 0,2,6,14,13,11,...
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-low reset (q returns to 0000)
//   en  : advance enable
//   q   : current LFSR value
// -----------------------------------------------------------------------------
module rng_lfsr4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [3:0] q
);

   logic [3:0] lfsr_q;
   logic [3:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en) begin
         lfsr_d = {lfsr_q[2], lfsr_q[1], lfsr_q[0] ~^ lfsr_q[3], lfsr_q[3]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         lfsr_q <= 4'b0000;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/game_round_ctrl.sv
// -----------------------------------------------------------------------------
// game_round_ctrl
// Round sequencer for the binary mental-math game. Samples two LFSR operands
// per round, shows them to the player, checks the 5-bit binary answer and
// accumulates a saturating score over ROUNDS rounds.
//
// Parameters:
//   ROUNDS         : rounds per game (1..255)
//   TIMEOUT_CYCLES : answer window in clk cycles (>= 2), GAME_TIMEOUT_EN only
//   SCORE_W        : score width
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-low reset
//   bus : game_round_ctrl_if.slave
//         in  start, ans_valid, ans
//         out op_a, op_b, show, correct, wrong, timeout, score, round_no,
//             busy, done
// Build option:
//   GAME_TIMEOUT_EN : when defined, an answer timer ends SHOW after
//                     TIMEOUT_CYCLES cycles with a wrong+timeout pulse; when
//                     undefined, SHOW waits indefinitely and timeout is 0.
// -----------------------------------------------------------------------------
module game_round_ctrl
   import game_pkg::*;
#(
   parameter int ROUNDS         = 8,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int SCORE_W        = 4
) (
   input  logic              clk,
   input  logic              rst,
   game_round_ctrl_if.slave  bus
);

   localparam logic [7:0]         LAST_ROUND = 8'(ROUNDS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == SCORE_MAX) ? v : v + 1'b1;
   endfunction

   state_t             state_q, state_d;
   logic [OP_W-1:0]    op_a_q, op_a_d;
   logic [OP_W-1:0]    op_b_q, op_b_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [7:0]         round_q, round_d;
   logic               correct_q, correct_d;
   logic               wrong_q, wrong_d;
   logic [OP_W-1:0]    lfsr;
   logic               lfsr_en;

`ifdef GAME_TIMEOUT_EN
   localparam int           TMR_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] timer_q, timer_d;
   logic             timeout_q, timeout_d;
`endif

   // The random source keeps running except while operands are on display,
   // so the player's think time does not change later operands.
   assign lfsr_en = rst & (state_q != SHOW);

   rng_lfsr4 u_rng (
      .clk (clk),
      .rst (rst),
      .en  (lfsr_en),
      .q   (lfsr)
   );

   always_comb begin
      state_d   = state_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      score_d   = score_q;
      round_d   = round_q;
      correct_d = 1'b0;
      wrong_d   = 1'b0;
`ifdef GAME_TIMEOUT_EN
      timer_d   = timer_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               score_d = '0;
               round_d = '0;
               state_d = LOAD_A;
            end
         end
         LOAD_A: begin
            op_a_d  = lfsr;
            state_d = LOAD_B;
         end
         LOAD_B: begin
            op_b_d  = lfsr;
`ifdef GAME_TIMEOUT_EN
            timer_d = '0;
`endif
            state_d = SHOW;
         end
         SHOW: begin
`ifdef GAME_TIMEOUT_EN
            timer_d = timer_q + 1'b1;
`endif
            // An answer on the terminal timer cycle takes priority.
            if (bus.ans_valid) begin
               if (bus.ans == op_sum(op_a_q, op_b_q)) begin
                  correct_d = 1'b1;
                  score_d   = sat_inc(score_q);
               end else begin
                  wrong_d = 1'b1;
               end
               state_d = NEXT;
            end
`ifdef GAME_TIMEOUT_EN
            else if (timer_q == TMR_LAST) begin
               wrong_d   = 1'b1;
               timeout_d = 1'b1;
               state_d   = NEXT;
            end
`endif
         end
         NEXT: begin
            if (round_q == LAST_ROUND) begin
               state_d = DONE;
            end else begin
               round_d = round_q + 8'd1;
               state_d = LOAD_A;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         op_a_q    <= '0;
         op_b_q    <= '0;
         score_q   <= '0;
         round_q   <= '0;
         correct_q <= 1'b0;
         wrong_q   <= 1'b0;
`ifdef GAME_TIMEOUT_EN
         timer_q   <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         score_q   <= score_d;
         round_q   <= round_d;
         correct_q <= correct_d;
         wrong_q   <= wrong_d;
`ifdef GAME_TIMEOUT_EN
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign bus.op_a     = op_a_q;
   assign bus.op_b     = op_b_q;
   assign bus.show     = (state_q == SHOW);
   assign bus.correct  = correct_q;
   assign bus.wrong    = wrong_q;
   assign bus.score    = score_q;
   assign bus.round_no = round_q;
   assign bus.busy     = (state_q != IDLE) && (state_q != DONE);
   assign bus.done     = (state_q == DONE);
`ifdef GAME_TIMEOUT_EN
   assign bus.timeout  = timeout_q;
`else
   assign bus.timeout  = 1'b0;
`endif

endmodule
